// File: rtl/hcs_alarm_manager.sv
// Alarm manager for healthCareSystem outputs: debounces five abnormality
// conditions into latched, acknowledgeable alarms and logs each raise in an event FIFO.
module hcs_alarm_manager #(
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sampleValid,
  input  logic                  presureAbnormality,
  input  logic                  bloodAbnormality,
  input  logic                  temperatureAbnormality,
  input  logic                  fallDetected,
  input  logic [3:0]            glycemicIndex,
  input  logic [3:0]            giHighLimit,
  input  logic [4:0]            ackAlarm,
  output logic [4:0]            alarmVector,
  output logic                  alarmAny,
  output logic                  evtValid,
  input  logic                  evtReady,
  output logic [TS_WIDTH+2:0]   evtData,
  output logic                  evtOverflow
);

  localparam int NCH = 5;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = TS_WIDTH + 3;
  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  typedef enum logic [1:0] {IDLE, ARMING, ACTIVE, WAIT_CLEAR} ch_state_e;

  ch_state_e             state_q [NCH];
  ch_state_e             state_d [NCH];
  logic [3:0]            cnt_q   [NCH];
  logic [3:0]            cnt_d   [NCH];
  logic [TS_WIDTH-1:0]   cap_q   [NCH];
  logic [TS_WIDTH-1:0]   cap_d   [NCH];
  logic [NCH-1:0]        cond_in, cond_q, cond_d, raise, pending_q, pending_d;
  logic [TS_WIDTH-1:0]   ts_q, ts_d;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  push_req, push_ok, pop, full;
  logic [EW-1:0]         push_data;
  logic [NCH-1:0]        push_mask;

  assign cond_in = {fallDetected, (glycemicIndex > giHighLimit),
                    temperatureAbnormality, bloodAbnormality, presureAbnormality};

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        cap_q[i]   <= '0;
      end
      cond_q    <= '0;
      pending_q <= '0;
      ts_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        cap_q[i]   <= cap_d[i];
      end
      cond_q    <= cond_d;
      pending_q <= pending_d;
      ts_q      <= ts_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Next-state logic for the per-channel alarm FSMs
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can
    // leave a value unassigned and infer a latch.
    cond_d = sampleValid ? cond_in : cond_q;
    raise  = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        IDLE: if (sampleValid && cond_in[i]) begin
          if (DEBOUNCE == 1 || i == NCH - 1) begin
            state_d[i] = ACTIVE;
            cnt_d[i]   = '0;
          end else begin
            state_d[i] = ARMING;
            cnt_d[i]   = 4'd1;
          end
        end
        ARMING: if (sampleValid) begin
          if (!cond_in[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] + 4'd1 >= DEB) begin
            state_d[i] = ACTIVE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + 4'd1;
          end
        end
        // An ack landing with a strobe judges the freshly sampled condition
        ACTIVE: if (ackAlarm[i]) state_d[i] = cond_d[i] ? WAIT_CLEAR : IDLE;
        WAIT_CLEAR: if (sampleValid && !cond_in[i]) state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
      raise[i] = (state_q[i] != ACTIVE) && (state_d[i] == ACTIVE);
      cap_d[i] = raise[i] ? ts_q : cap_q[i];
    end
  end

  // Outputs of the alarm FSMs
  always_comb begin
    alarmVector = '0;
    for (int i = 0; i < NCH; i++) alarmVector[i] = (state_q[i] == ACTIVE);
    alarmAny = |alarmVector;
  end

  // Pending-event arbitration: fall first, then channels 0..3 in index order
  always_comb begin
    push_mask = '0;
    push_data = '0;
    if (pending_q[4])      begin push_mask = 5'b10000; push_data = {3'd4, cap_q[4]}; end
    else if (pending_q[0]) begin push_mask = 5'b00001; push_data = {3'd0, cap_q[0]}; end
    else if (pending_q[1]) begin push_mask = 5'b00010; push_data = {3'd1, cap_q[1]}; end
    else if (pending_q[2]) begin push_mask = 5'b00100; push_data = {3'd2, cap_q[2]}; end
    else if (pending_q[3]) begin push_mask = 5'b01000; push_data = {3'd3, cap_q[3]}; end
    push_req  = |pending_q;
    pending_d = (pending_q & ~push_mask) | raise;
    ts_d      = sampleValid ? ts_q + TS_WIDTH'(1) : ts_q;
  end

  // Event FIFO control
  always_comb begin
    full     = (count_q == (AW+1)'(FIFO_DEPTH));
    pop      = evtValid && evtReady;
    push_ok  = push_req && (!full || pop);
    ovf_d    = ovf_q | (push_req && full && !pop);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push_ok) count_d = count_q - (AW+1)'(1);
  end

  // NOTE: the storage array has no reset; emptiness is tracked by count_q and
  // evtData is gated, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  assign evtValid    = (count_q != '0);
  assign evtData     = evtValid ? mem[rd_ptr_q] : '0;
  assign evtOverflow = ovf_q;

endmodule

// File: tb/tb_hcs_alarm_manager.sv
// Self-checking bench for hcs_alarm_manager: table-driven alarm vectors plus
// hand sequences, with a queue scoreboard for the logged events.
module tb_hcs_alarm_manager;

  logic        clk = 1'b0;
  logic        rst;
  logic        sampleValid, presureAbnormality, bloodAbnormality;
  logic        temperatureAbnormality, fallDetected;
  logic [3:0]  glycemicIndex, giHighLimit;
  logic [4:0]  ackAlarm;
  logic [4:0]  alarmVector;
  logic        alarmAny, evtValid, evtReady, evtOverflow;
  logic [10:0] evtData;

  hcs_alarm_manager #(.DEBOUNCE(3), .FIFO_DEPTH(8), .TS_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .sampleValid(sampleValid),
    .presureAbnormality(presureAbnormality), .bloodAbnormality(bloodAbnormality),
    .temperatureAbnormality(temperatureAbnormality), .fallDetected(fallDetected),
    .glycemicIndex(glycemicIndex), .giHighLimit(giHighLimit), .ackAlarm(ackAlarm),
    .alarmVector(alarmVector), .alarmAny(alarmAny), .evtValid(evtValid),
    .evtReady(evtReady), .evtData(evtData), .evtOverflow(evtOverflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sv;
    logic       p, b, t, f;
    logic [3:0] gi, lim;
    logic [4:0] ack;
    logic [4:0] exp_alarm;
    logic [4:0] raise;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  sc    = '0;
  logic [10:0] exp_q[$];
  vec_t        tbl[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic vec_t mk(input logic sv, input logic p, input logic b, input logic t,
                              input logic f, input logic [3:0] gi, input logic [3:0] lim,
                              input logic [4:0] ack, input logic [4:0] exp_alarm,
                              input logic [4:0] raise);
    vec_t v;
    v.sv = sv; v.p = p; v.b = b; v.t = t; v.f = f; v.gi = gi; v.lim = lim;
    v.ack = ack; v.exp_alarm = exp_alarm; v.raise = raise;
    return v;
  endfunction

  // One clock with the given inputs; expected events enter the scoreboard in push priority order
  task automatic apply(input string tag, input vec_t v);
    int ord[5] = '{4, 0, 1, 2, 3};
    sampleValid = v.sv; presureAbnormality = v.p; bloodAbnormality = v.b;
    temperatureAbnormality = v.t; fallDetected = v.f;
    glycemicIndex = v.gi; giHighLimit = v.lim; ackAlarm = v.ack;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++)
      if (v.raise[ord[k]]) exp_q.push_back({3'(ord[k]), sc});
    if (v.sv) sc = sc + 8'd1;
    sampleValid = 1'b0; ackAlarm = '0;
    check({tag, "_alarmVector"}, 32'(alarmVector), 32'(v.exp_alarm));
    check({tag, "_alarmAny"}, 32'(alarmAny), 32'(|v.exp_alarm));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
  endtask

  // Pop everything the DUT offers, comparing against the scoreboard
  task automatic drain(input string tag);
    int budget = 60;
    logic [10:0] want;
    while (budget > 0 && (evtValid || exp_q.size() != 0)) begin
      if (evtValid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL %s_extra: got event %0h expected none", tag, evtData);
        end else begin
          want = exp_q.pop_front();
          check({tag, "_evt"}, 32'(evtData), 32'(want));
        end
        evtReady = 1'b1;
        @(posedge clk); #1;
        evtReady = 1'b0;
      end else begin
        idle(1);
      end
      budget--;
    end
    check({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_empty"}, 32'(evtValid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alarmVector"}, 32'(alarmVector), 32'd0);
    check({tag, "_alarmAny"}, 32'(alarmAny), 32'd0);
    check({tag, "_evtValid"}, 32'(evtValid), 32'd0);
    check({tag, "_evtData"}, 32'(evtData), 32'd0);
    check({tag, "_evtOverflow"}, 32'(evtOverflow), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z;
    rst = 1'b1; sampleValid = 1'b0; presureAbnormality = 1'b0; bloodAbnormality = 1'b0;
    temperatureAbnormality = 1'b0; fallDetected = 1'b0; glycemicIndex = '0;
    giHighLimit = 4'd9; ackAlarm = '0; evtReady = 1'b0;

    // Stimulus table: sv p b t f gi lim ack exp raise
    tbl.push_back(mk(1,0,0,0,0, 0,9, 5'b00001, 5'b00000, 5'b00000)); // ack pressure, cond now 0
    tbl.push_back(mk(1,1,0,0,0, 0,9, 5'b00000, 5'b00000, 5'b00000)); // pattern 1,1,0,1,1
    tbl.push_back(mk(1,1,0,0,0, 0,9, 5'b00000, 5'b00000, 5'b00000));
    tbl.push_back(mk(1,0,0,0,0, 0,9, 5'b00000, 5'b00000, 5'b00000));
    tbl.push_back(mk(1,1,0,0,0, 0,9, 5'b00000, 5'b00000, 5'b00000));
    tbl.push_back(mk(1,1,0,0,0, 0,9, 5'b00000, 5'b00000, 5'b00000));
    tbl.push_back(mk(1,0,0,0,0, 0,9, 5'b00000, 5'b00000, 5'b00000));
    tbl.push_back(mk(1,0,1,0,0, 0,9, 5'b00000, 5'b00000, 5'b00000)); // blood arming
    tbl.push_back(mk(1,0,1,0,0, 0,9, 5'b00000, 5'b00000, 5'b00000));
    tbl.push_back(mk(1,0,1,0,1, 0,9, 5'b00000, 5'b10010, 5'b10010)); // fall + blood together
    tbl.push_back(mk(1,0,0,0,0, 0,9, 5'b10010, 5'b00000, 5'b00000));
    for (int k = 0; k < 5; k++)                                       // gi == limit: no alarm
      tbl.push_back(mk(1,0,0,0,0, 9,9, 5'b00000, 5'b00000, 5'b00000));
    tbl.push_back(mk(1,0,0,0,0,10,9, 5'b00000, 5'b00000, 5'b00000));
    tbl.push_back(mk(1,0,0,0,0,10,9, 5'b00000, 5'b00000, 5'b00000));
    tbl.push_back(mk(1,0,0,0,0,10,9, 5'b00000, 5'b01000, 5'b01000));
    tbl.push_back(mk(1,0,0,0,0, 0,9, 5'b01000, 5'b00000, 5'b00000));
    tbl.push_back(mk(1,0,0,1,0, 0,9, 5'b00000, 5'b00000, 5'b00000)); // temperature
    tbl.push_back(mk(1,0,0,1,0, 0,9, 5'b00000, 5'b00000, 5'b00000));
    tbl.push_back(mk(1,0,0,1,0, 0,9, 5'b00000, 5'b00100, 5'b00100));
    tbl.push_back(mk(0,0,0,1,0, 0,9, 5'b00100, 5'b00000, 5'b00000)); // ack, cond still 1
    for (int k = 0; k < 3; k++)                                       // no re-raise
      tbl.push_back(mk(1,0,0,1,0, 0,9, 5'b00000, 5'b00000, 5'b00000));
    tbl.push_back(mk(1,0,0,0,0, 0,9, 5'b00000, 5'b00000, 5'b00000));
    tbl.push_back(mk(1,0,0,1,0, 0,9, 5'b00000, 5'b00000, 5'b00000));
    tbl.push_back(mk(1,0,0,1,0, 0,9, 5'b00100, 5'b00000, 5'b00000)); // ack while arming
    tbl.push_back(mk(1,0,0,1,0, 0,9, 5'b00100, 5'b00100, 5'b00100)); // ack on raise edge
    tbl.push_back(mk(0,0,0,1,0, 0,9, 5'b00000, 5'b00100, 5'b00000));
    tbl.push_back(mk(1,0,0,0,0, 0,9, 5'b00100, 5'b00000, 5'b00000));

    // Reset state
    idle(2);
    check_reset_outputs("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // First raise and its push latency
    apply("p0", mk(1,1,0,0,0, 0,9, 5'b00000, 5'b00000, 5'b00000));
    apply("p1", mk(1,1,0,0,0, 0,9, 5'b00000, 5'b00000, 5'b00000));
    apply("p2", mk(1,1,0,0,0, 0,9, 5'b00000, 5'b00001, 5'b00001));
    check("push_not_early", 32'(evtValid), 32'd0);
    apply("p3", mk(0,0,0,0,0, 0,9, 5'b00000, 5'b00001, 5'b00000));
    check("first_evtValid", 32'(evtValid), 32'd1);
    check("first_evtData", 32'(evtData), 32'h002);
    drain("first");

    foreach (tbl[i]) apply($sformatf("row%0d", i), tbl[i]);
    drain("table");

    // Nine fall raises with no consumer: eight held, one dropped
    for (int r = 0; r < 9; r++) begin
      apply("ovf_raise", mk(1,0,0,0,1, 0,9, 5'b00000, 5'b10000, (r < 8) ? 5'b10000 : 5'b00000));
      apply("ovf_ack",   mk(1,0,0,0,0, 0,9, 5'b10000, 5'b00000, 5'b00000));
      if (r == 7) begin
        check("full_no_overflow", 32'(evtOverflow), 32'd0);
        check("full_valid", 32'(evtValid), 32'd1);
      end
    end
    check("overflow_set", 32'(evtOverflow), 32'd1);

    // Raise while full, push lands on a popping edge
    apply("fullpop_raise", mk(1,0,0,0,1, 0,9, 5'b00000, 5'b10000, 5'b10000));
    evtReady = 1'b1;
    check("fullpop_head", 32'(evtData), 32'(exp_q.pop_front()));
    apply("fullpop_ack", mk(1,0,0,0,0, 0,9, 5'b10000, 5'b00000, 5'b00000));
    evtReady = 1'b0;
    check("overflow_sticky", 32'(evtOverflow), 32'd1);
    drain("fullpop");

    // Asynchronous reset mid-operation
    apply("mid_f", mk(1,0,0,0,1, 0,9, 5'b00000, 5'b10000, 5'b10000));
    apply("mid_p", mk(1,1,0,0,0, 0,9, 5'b00000, 5'b10000, 5'b00000));
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    exp_q.delete();
    sc = '0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    idle(3);
    check("post_reset_empty", 32'(evtValid), 32'd0);
    z = mk(1,1,0,0,0, 0,9, 5'b00000, 5'b00000, 5'b00000);
    apply("r0", z);
    apply("r1", z);
    apply("r2", mk(1,1,0,0,0, 0,9, 5'b00000, 5'b00001, 5'b00001));
    drain("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
